// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus carrying the 4-word input PIO register map.
interface pio_in_edge_irq_if;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned DATA_W = 32;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport master (output address, chipselect, write, writedata, input readdata);
   modport slave  (input address, chipselect, write, writedata, output readdata);
endinterface

// File: rtl/pio_in_edge_irq.sv
// Input PIO: synchroniser, optional per-bit debounce, edge capture and masked level irq.
module pio_in_edge_irq #(
   parameter int unsigned      WIDTH           = 8,
   parameter int unsigned      EDGE_TYPE       = 0,
   parameter int unsigned      DEBOUNCE_CYCLES = 0,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             clk,
   input  logic             reset,
   pio_in_edge_irq_if.slave bus,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);
   localparam int unsigned DATA_W    = 32;
   localparam logic [1:0]  ADDR_DATA = 2'd0;
   localparam logic [1:0]  ADDR_MASK = 2'd2;
   localparam logic [1:0]  ADDR_EDGE = 2'd3;

   logic [WIDTH-1:0]  sync1;
   logic [WIDTH-1:0]  sync2;
   logic [WIDTH-1:0]  filt;
   logic [WIDTH-1:0]  filt_d;
   logic [WIDTH-1:0]  rise;
   logic [WIDTH-1:0]  fall;
   logic [WIDTH-1:0]  edge_ev;
   logic [WIDTH-1:0]  clr;
   logic [WIDTH-1:0]  irqmask;
   logic [WIDTH-1:0]  edgecapture;
   logic              wr_mask;
   logic              wr_edge;
   logic [DATA_W-1:0] rd_mux;

   // Two-flop synchroniser for the asynchronous inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= RESET_VALUE;
         sync2 <= RESET_VALUE;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt = sync2;
   end else begin : g_debounce
      localparam int unsigned   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt [WIDTH];
      logic [WIDTH-1:0] filt_q;

      // Per-bit stability counter; filt follows sync2 only after a full run of differing samples
      always_ff @(posedge clk) begin
         if (reset) begin
            filt_q <= RESET_VALUE;
            for (int i = 0; i < int'(WIDTH); i++) cnt[i] <= '0;
         end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
               if (sync2[i] == filt_q[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == CNT_LAST) begin
                  filt_q[i] <= sync2[i];
                  cnt[i]    <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end
         end
      end

      assign filt = filt_q;
   end

   // Delayed filtered value for edge detection; reset matches filt so reset makes no edge
   always_ff @(posedge clk) begin
      if (reset) filt_d <= RESET_VALUE;
      else       filt_d <= filt;
   end

   assign rise = filt & ~filt_d;
   assign fall = ~filt & filt_d;

   // Select which transitions count as edges
   always_comb begin
      edge_ev = rise;
      if (EDGE_TYPE == 1)      edge_ev = fall;
      else if (EDGE_TYPE == 2) edge_ev = rise | fall;
   end

   assign wr_mask = bus.chipselect & bus.write & (bus.address == ADDR_MASK);
   assign wr_edge = bus.chipselect & bus.write & (bus.address == ADDR_EDGE);
   assign clr     = wr_edge ? bus.writedata[WIDTH-1:0] : '0;

   // Mask and write-1-to-clear capture registers; a new edge beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset) begin
         irqmask     <= '0;
         edgecapture <= '0;
      end else begin
         if (wr_mask) irqmask <= bus.writedata[WIDTH-1:0];
         edgecapture <= (edgecapture & ~clr) | edge_ev;
      end
   end

   // Zero-extended read mux
   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_DATA: rd_mux = DATA_W'(filt);
         ADDR_MASK: rd_mux = DATA_W'(irqmask);
         ADDR_EDGE: rd_mux = DATA_W'(edgecapture);
         default:   rd_mux = '0;
      endcase
   end

   // Registered read data, one cycle latency
   always_ff @(posedge clk) begin
      if (reset) bus.readdata <= '0;
      else       bus.readdata <= rd_mux;
   end

   // Level interrupt built only from registers
   assign irq = |(edgecapture & irqmask);

   if (WIDTH < DATA_W) begin : g_unused
      logic unused_wd;
      assign unused_wd = ^bus.writedata[DATA_W-1:WIDTH];
   end
endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: six configurations share one stimulus, checked against a model.
module tb_pio_in_edge_irq;
   localparam int NI = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic        cs;
   logic        wr;
   logic [31:0] wd;
   logic [31:0] pin;
   logic [31:0] rd_dut [NI];
   logic        irq_dut [NI];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   pio_in_edge_irq_if bif0 ();
   pio_in_edge_irq_if bif1 ();
   pio_in_edge_irq_if bif2 ();
   pio_in_edge_irq_if bif3 ();
   pio_in_edge_irq_if bif4 ();
   pio_in_edge_irq_if bif5 ();

   assign bif0.address = addr; assign bif0.chipselect = cs; assign bif0.write = wr; assign bif0.writedata = wd;
   assign bif1.address = addr; assign bif1.chipselect = cs; assign bif1.write = wr; assign bif1.writedata = wd;
   assign bif2.address = addr; assign bif2.chipselect = cs; assign bif2.write = wr; assign bif2.writedata = wd;
   assign bif3.address = addr; assign bif3.chipselect = cs; assign bif3.write = wr; assign bif3.writedata = wd;
   assign bif4.address = addr; assign bif4.chipselect = cs; assign bif4.write = wr; assign bif4.writedata = wd;
   assign bif5.address = addr; assign bif5.chipselect = cs; assign bif5.write = wr; assign bif5.writedata = wd;
   assign rd_dut[0] = bif0.readdata; assign rd_dut[1] = bif1.readdata; assign rd_dut[2] = bif2.readdata;
   assign rd_dut[3] = bif3.readdata; assign rd_dut[4] = bif4.readdata; assign rd_dut[5] = bif5.readdata;

   pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0), .RESET_VALUE(8'h00)) u_d0 (
      .clk(clk), .reset(reset), .bus(bif0.slave), .in_port(pin[7:0]), .irq(irq_dut[0]));
   pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0), .RESET_VALUE(8'h00)) u_d1 (
      .clk(clk), .reset(reset), .bus(bif1.slave), .in_port(pin[7:0]), .irq(irq_dut[1]));
   pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0), .RESET_VALUE(8'h00)) u_d2 (
      .clk(clk), .reset(reset), .bus(bif2.slave), .in_port(pin[7:0]), .irq(irq_dut[2]));
   pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4), .RESET_VALUE(8'h00)) u_d3 (
      .clk(clk), .reset(reset), .bus(bif3.slave), .in_port(pin[7:0]), .irq(irq_dut[3]));
   pio_in_edge_irq #(.WIDTH(32), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0), .RESET_VALUE(32'h0)) u_d4 (
      .clk(clk), .reset(reset), .bus(bif4.slave), .in_port(pin), .irq(irq_dut[4]));
   pio_in_edge_irq #(.WIDTH(5), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(2), .RESET_VALUE(5'h0A)) u_d5 (
      .clk(clk), .reset(reset), .bus(bif5.slave), .in_port(pin[4:0]), .irq(irq_dut[5]));

   // Configuration of each instance, as seen by the model
   function automatic int cfg_w(int i);
      case (i) 4: return 32; 5: return 5; default: return 8; endcase
   endfunction
   function automatic int cfg_et(int i);
      case (i) 1: return 1; 2: return 2; 5: return 2; default: return 0; endcase
   endfunction
   function automatic int cfg_db(int i);
      case (i) 3: return 4; 5: return 2; default: return 0; endcase
   endfunction
   function automatic logic [31:0] cfg_rv(int i);
      return (i == 5) ? 32'h0000_000A : 32'h0;
   endfunction
   function automatic logic [31:0] wmask(int i);
      return 32'((64'h1 << cfg_w(i)) - 64'h1);
   endfunction

   // Reference model: input history, run-length debounce, capture/mask/read registers
   logic [31:0] m_s1 [NI], m_s2 [NI], m_filt [NI], m_fd [NI];
   logic [31:0] m_cap [NI], m_mask [NI], m_rd [NI], m_last [NI];
   int          m_run [NI][32];

   function automatic logic [31:0] m_filt_now(int i);
      return (cfg_db(i) == 0) ? m_s2[i] : m_filt[i];
   endfunction

   task automatic model_step();
      logic [31:0] wm, fc, ev, clr, rdn;
      for (int i = 0; i < NI; i++) begin
         wm = wmask(i);
         if (reset) begin
            m_s1[i] = cfg_rv(i); m_s2[i] = cfg_rv(i); m_filt[i] = cfg_rv(i); m_fd[i] = cfg_rv(i);
            m_cap[i] = '0; m_mask[i] = '0; m_rd[i] = '0;
            for (int b = 0; b < 32; b++) m_run[i][b] = 0;
         end else begin
            fc = m_filt_now(i);
            case (cfg_et(i))
               1:       ev = ~fc & m_fd[i] & wm;
               2:       ev = (fc ^ m_fd[i]) & wm;
               default: ev = fc & ~m_fd[i] & wm;
            endcase
            clr = (cs && wr && addr == 2'd3) ? (wd & wm) : 32'h0;
            case (addr)
               2'd0:    rdn = fc;
               2'd2:    rdn = m_mask[i];
               2'd3:    rdn = m_cap[i];
               default: rdn = 32'h0;
            endcase
            m_cap[i] = (m_cap[i] & ~clr) | ev;
            if (cs && wr && addr == 2'd2) m_mask[i] = wd & wm;
            m_fd[i] = fc;
            if (cfg_db(i) != 0) begin
               for (int b = 0; b < cfg_w(i); b++) begin
                  if (m_run[i][b] != 0 && m_s2[i][b] == m_last[i][b]) m_run[i][b]++;
                  else m_run[i][b] = 1;
                  m_last[i][b] = m_s2[i][b];
                  if (m_s2[i][b] != m_filt[i][b] && m_run[i][b] >= cfg_db(i))
                     m_filt[i][b] = m_s2[i][b];
               end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = pin & wm;
            m_rd[i] = rdn;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle, every instance is compared with the model
   always @(posedge clk) begin
      model_step();
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("model rd inst%0d", i), rd_dut[i], m_rd[i]);
         check($sformatf("model irq inst%0d", i), {31'b0, irq_dut[i]}, {31'b0, |(m_cap[i] & m_mask[i])});
      end
   end

   task automatic drive(input logic r, input logic [31:0] p, input logic c, input logic w,
                        input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      reset = r; pin = p; cs = c; wr = w; addr = a; wd = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic [31:0] pin;
      logic        cs;
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t tbl [26];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] p;
      reset = 1'b1; pin = '0; cs = 1'b0; wr = 1'b0; addr = '0; wd = '0;

      // Bypass / rising instance 0: reset, latency, mask, clear, set-wins, ignored writes
      tbl[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 2'd0, 32'h0, 32'h00, 1'b0};
      tbl[1]  = '{1'b1, 32'h00, 1'b0, 1'b0, 2'd0, 32'h0, 32'h00, 1'b0};
      tbl[2]  = '{1'b1, 32'h00, 1'b0, 1'b0, 2'd0, 32'h0, 32'h00, 1'b0};
      tbl[3]  = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd0, 32'h0, 32'h00, 1'b0};
      tbl[4]  = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd0, 32'h0, 32'h00, 1'b0};
      tbl[5]  = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd0, 32'h0, 32'hA5, 1'b0};
      tbl[6]  = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd3, 32'h0, 32'hA5, 1'b0};
      tbl[7]  = '{1'b0, 32'hA5, 1'b1, 1'b1, 2'd2, 32'h01, 32'h00, 1'b1};
      tbl[8]  = '{1'b0, 32'hA5, 1'b1, 1'b1, 2'd3, 32'hFF, 32'hA5, 1'b0};
      tbl[9]  = '{1'b0, 32'hA4, 1'b1, 1'b0, 2'd3, 32'h0, 32'h00, 1'b0};
      tbl[10] = '{1'b0, 32'hA4, 1'b1, 1'b0, 2'd3, 32'h0, 32'h00, 1'b0};
      tbl[11] = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd3, 32'h0, 32'h00, 1'b0};
      tbl[12] = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd3, 32'h0, 32'h00, 1'b0};
      tbl[13] = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd3, 32'h0, 32'h00, 1'b1};
      tbl[14] = '{1'b0, 32'hA5, 1'b1, 1'b1, 2'd3, 32'h01, 32'h01, 1'b0};
      tbl[15] = '{1'b0, 32'hA4, 1'b1, 1'b0, 2'd3, 32'h0, 32'h00, 1'b0};
      tbl[16] = '{1'b0, 32'hA4, 1'b1, 1'b0, 2'd3, 32'h0, 32'h00, 1'b0};
      tbl[17] = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd3, 32'h0, 32'h00, 1'b0};
      tbl[18] = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd3, 32'h0, 32'h00, 1'b0};
      tbl[19] = '{1'b0, 32'hA5, 1'b1, 1'b1, 2'd3, 32'h01, 32'h00, 1'b1};
      tbl[20] = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd3, 32'h0, 32'h01, 1'b1};
      tbl[21] = '{1'b0, 32'hA5, 1'b1, 1'b1, 2'd0, 32'hDEADBEEF, 32'hA5, 1'b1};
      tbl[22] = '{1'b0, 32'hA5, 1'b1, 1'b1, 2'd1, 32'hDEADBEEF, 32'h00, 1'b1};
      tbl[23] = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd2, 32'h0, 32'h01, 1'b1};
      tbl[24] = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd3, 32'h0, 32'h01, 1'b1};
      tbl[25] = '{1'b0, 32'hA5, 1'b1, 1'b0, 2'd1, 32'h0, 32'h00, 1'b1};

      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].rst, tbl[i].pin, tbl[i].cs, tbl[i].wr, tbl[i].addr, tbl[i].wd);
         tick();
         check($sformatf("tbl%0d rd", i), rd_dut[0], tbl[i].exp_rd);
         check($sformatf("tbl%0d irq", i), {31'b0, irq_dut[0]}, {31'b0, tbl[i].exp_irq});
      end

      // Falling / any edge on bit3
      repeat (3) drive(1'b1, 32'h08, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (4) drive(1'b0, 32'h08, 1'b0, 1'b0, 2'd0, 32'h0);
      drive(1'b0, 32'h08, 1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF);
      repeat (4) drive(1'b0, 32'h00, 1'b0, 1'b0, 2'd0, 32'h0);
      drive(1'b0, 32'h00, 1'b1, 1'b0, 2'd3, 32'h0);
      tick();
      check("fall edge rising-mode", rd_dut[0], 32'h00);
      check("fall edge falling-mode", rd_dut[1], 32'h08);
      check("fall edge any-mode", rd_dut[2], 32'h08);
      drive(1'b0, 32'h00, 1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF);
      repeat (4) drive(1'b0, 32'h08, 1'b0, 1'b0, 2'd0, 32'h0);
      drive(1'b0, 32'h08, 1'b1, 1'b0, 2'd3, 32'h0);
      tick();
      check("rise edge rising-mode", rd_dut[0], 32'h08);
      check("rise edge falling-mode", rd_dut[1], 32'h00);
      check("rise edge any-mode", rd_dut[2], 32'h08);

      // Debounce: short glitch rejected, long pulse accepted after 4 stable cycles
      repeat (3) drive(1'b1, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (3) drive(1'b0, 32'h04, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (8) drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 32'h0);
      tick();
      check("glitch filt", rd_dut[3], 32'h0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 2'd3, 32'h0);
      tick();
      check("glitch capture", rd_dut[3], 32'h0);
      for (int j = 0; j < 8; j++) begin
         drive(1'b0, (j < 6) ? 32'h04 : 32'h0, 1'b1, 1'b0, 2'd0, 32'h0);
         tick();
         check($sformatf("debounce filt cyc%0d", j), rd_dut[3], (j >= 6) ? 32'h04 : 32'h0);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 2'd3, 32'h0);
      tick();
      check("debounce capture", rd_dut[3], 32'h04);

      // Reset in the middle of a debounce count
      repeat (12) drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (4) drive(1'b0, 32'h04, 1'b0, 1'b0, 2'd0, 32'h0);
      drive(1'b1, 32'h04, 1'b0, 1'b0, 2'd0, 32'h0);
      for (int j = 1; j <= 7; j++) begin
         drive(1'b0, 32'h04, 1'b1, 1'b0, 2'd0, 32'h0);
         tick();
         check($sformatf("post-reset filt cyc%0d", j), rd_dut[3], (j >= 7) ? 32'h04 : 32'h0);
      end
      drive(1'b0, 32'h04, 1'b1, 1'b0, 2'd3, 32'h0);
      tick();
      check("post-reset capture", rd_dut[3], 32'h04);

      // 32-bit power-up edge on every bit
      repeat (3) drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (3) drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd0, 32'h0);
      drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd3, 32'h0);
      tick();
      check("power-up capture w32", rd_dut[4], 32'hFFFF_FFFF);

      // Narrow instance reads zero above bit 4 on every address
      drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF);
      for (int a = 0; a < 4; a++) begin
         drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'(a), 32'h0);
         tick();
         check($sformatf("w5 upper bits addr%0d", a), rd_dut[5] & 32'hFFFF_FFE0, 32'h0);
      end

      // Random traffic against the model
      p = 32'h0;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) p = p ^ ($urandom & $urandom & $urandom);
         drive(($urandom_range(0, 79) == 0), p, 1'($urandom), 1'($urandom),
               2'($urandom), ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom);
      end
      repeat (4) drive(1'b0, p, 1'b0, 1'b0, 2'd0, 32'h0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
